// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC generation, imem req/ack, {pc, inst} buffer
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

    state_t         state, state_nx;
    logic [31:0]    req_addr, req_addr_nx;
    logic [31:0]    next_pc, next_pc_nx;
    logic [31:0]    buf_pc   [BUF_DEPTH];
    logic [31:0]    buf_inst [BUF_DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count, count_nx;
    logic           ack_acc, push, pop;

    // Request is gated by reset so it drops immediately on async assertion.
    assign imem_req_o  = rst && (state != S_HOLD);
    assign imem_addr_o = req_addr;
    assign valid_o     = (count != '0);
    assign pc_o        = valid_o ? buf_pc[rd_ptr]   : 32'h0;
    assign inst_o      = valid_o ? buf_inst[rd_ptr] : 32'h0;

    assign ack_acc = imem_req_o & imem_ack_i;
    assign pop     = valid_o & ~stall_i;
    assign push    = (state == S_REQ) & ack_acc & ~redirect_i;

    always_comb begin
        state_nx    = state;
        req_addr_nx = req_addr;
        next_pc_nx  = next_pc;
        count_nx    = count + CW'(push) - CW'(pop);
        case (state)
            S_REQ: begin
                if (redirect_i) begin
                    if (ack_acc) begin
                        req_addr_nx = redirect_pc_i;
                    end else begin
                        next_pc_nx = redirect_pc_i;
                        state_nx   = S_DROP;
                    end
                end else if (push) begin
                    req_addr_nx = req_addr + 32'd4;
                    if (count_nx == CW'(BUF_DEPTH)) begin
                        state_nx = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    req_addr_nx = redirect_pc_i;
                    state_nx    = S_REQ;
                end else if (pop) begin
                    state_nx = S_REQ;
                end
            end
            S_DROP: begin
                // The outstanding request must complete; its data is thrown away.
                if (redirect_i) begin
                    if (ack_acc) begin
                        req_addr_nx = redirect_pc_i;
                        state_nx    = S_REQ;
                    end else begin
                        next_pc_nx = redirect_pc_i;
                    end
                end else if (ack_acc) begin
                    req_addr_nx = next_pc;
                    state_nx    = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
        if (redirect_i) begin
            count_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            req_addr <= RESET_PC;
            next_pc  <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_nx;
            req_addr <= req_addr_nx;
            next_pc  <= next_pc_nx;
            count    <= count_nx;
            if (redirect_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push) wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= req_addr;
            buf_inst[wr_ptr] <= imem_rdata_i;
        end
    end
endmodule
